// File: rtl/eth_cmd_rx.sv
// eth_cmd_rx: extracts 33-bit command records from private-ethertype
// Ethernet frames on the RX byte stream and queues them in a FIFO.
// Entries become visible downstream only once their frame has ended cleanly.
// Optional build macro ETH_CMD_RX_FCS_CHECK_EN adds a CRC-32 check of the FCS.
// Without it, the FCS bytes are skipped.
module eth_cmd_rx #(
  parameter logic [47:0] MAC_ADDR  = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int          FIFO_AW   = 4,
  parameter int          MAX_CMDS  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_dv,
  output logic [32:0] cmd_data,
  output logic        cmd_vld,
  input  logic        cmd_rdy,
  output logic [15:0] frame_ok_cnt,
  output logic [15:0] frame_drop_cnt,
  output logic        overflow
);

  localparam int              DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [7:0]      MAX_N    = 8'(MAX_CMDS);

  typedef enum logic [2:0] {IDLE, PRE, HDR, CNT, PAY, TAIL, DISCARD} state_t;

  state_t           state, state_nx;
  logic [FIFO_AW:0] wr_ptr, cmt_ptr, rd_ptr, used;
  logic [32:0]      mem [DEPTH];
  logic [3:0]       hdr_idx;
  logic [2:0]       byte_idx;
  logic [7:0]       rec_cnt, rec_total;
  logic             rec_b32;
  logic [23:0]      rec_sh;
  logic [32:0]      wr_data;
  logic             uc_ok, bc_ok, et_ok, uc_now, bc_now, et_now;
  logic [7:0]       exp_byte;
  logic             silent, ovf_frame;
  logic             start_hdr, load_cnt, wr_en, commit, rollback, count_drop;
  logic             mark_silent, mark_ovf, crc_ok;

  assign used     = wr_ptr - rd_ptr;
  assign wr_data  = {rec_b32, rec_sh, rx_data};
  assign cmd_vld  = (rd_ptr != cmt_ptr);
  assign cmd_data = cmd_vld ? mem[rd_ptr[FIFO_AW-1:0]] : '0;
  assign uc_now   = uc_ok && (rx_data == exp_byte);
  assign bc_now   = bc_ok && (rx_data == 8'hFF);
  assign et_now   = et_ok && (rx_data == exp_byte);

`ifdef ETH_CMD_RX_FCS_CHECK_EN
  logic [31:0] crc;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Reflected CRC-32 over dst through FCS; the MSB-first residue 0xC704DD7B reads as 0xDEBB20E3 here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc <= 32'hFFFF_FFFF;
    else if (start_hdr) crc <= 32'hFFFF_FFFF;
    else if (rx_dv && (state == HDR || state == CNT || state == PAY || state == TAIL))
      crc <= crc_step(crc, rx_data);
  end

  assign crc_ok = (crc == 32'hDEBB_20E3);
`else
  assign crc_ok = 1'b1;
`endif

  // Expected header byte for the dst MAC and ethertype positions
  always_comb begin
    exp_byte = 8'h00;
    case (hdr_idx)
      4'd0:    exp_byte = MAC_ADDR[47:40];
      4'd1:    exp_byte = MAC_ADDR[39:32];
      4'd2:    exp_byte = MAC_ADDR[31:24];
      4'd3:    exp_byte = MAC_ADDR[23:16];
      4'd4:    exp_byte = MAC_ADDR[15:8];
      4'd5:    exp_byte = MAC_ADDR[7:0];
      4'd12:   exp_byte = ETHERTYPE[15:8];
      4'd13:   exp_byte = ETHERTYPE[7:0];
      default: exp_byte = 8'h00;
    endcase
  end

  // Parser state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and per-byte control strobes; rx_dv low ends the frame from any state
  always_comb begin
    state_nx    = state;
    start_hdr   = 1'b0;
    load_cnt    = 1'b0;
    wr_en       = 1'b0;
    commit      = 1'b0;
    rollback    = 1'b0;
    count_drop  = 1'b0;
    mark_silent = 1'b0;
    mark_ovf    = 1'b0;
    if (state != IDLE && !rx_dv) begin
      state_nx = IDLE;
      if (state == TAIL && !ovf_frame && crc_ok) begin
        commit = 1'b1;
      end else begin
        rollback   = 1'b1;
        count_drop = !silent;
      end
    end else if (rx_dv) begin
      case (state)
        IDLE, PRE: begin
          if (rx_data == 8'hD5) begin
            state_nx  = HDR;
            start_hdr = 1'b1;
          end else if (rx_data == 8'h55) begin
            state_nx = PRE;
          end else begin
            state_nx = DISCARD;
          end
        end
        HDR: begin
          if (hdr_idx == 4'd5 && !(uc_now || bc_now)) begin
            state_nx    = DISCARD;
            mark_silent = 1'b1;
          end else if (hdr_idx == 4'd13) begin
            if (et_now) begin
              state_nx = CNT;
            end else begin
              state_nx    = DISCARD;
              mark_silent = 1'b1;
            end
          end
        end
        CNT: begin
          if (rx_data == 8'h00 || rx_data > MAX_N) begin
            state_nx = DISCARD;
          end else begin
            state_nx = PAY;
            load_cnt = 1'b1;
          end
        end
        PAY: begin
          if (byte_idx == 3'd4) begin
            if (used == FULL_LVL) begin
              state_nx = DISCARD;
              mark_ovf = 1'b1;
            end else begin
              wr_en = 1'b1;
              if (rec_cnt + 8'd1 == rec_total) state_nx = TAIL;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Header match flags, record assembly and per-frame status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_idx   <= '0;
      uc_ok     <= 1'b0;
      bc_ok     <= 1'b0;
      et_ok     <= 1'b0;
      byte_idx  <= '0;
      rec_cnt   <= '0;
      rec_total <= '0;
      rec_b32   <= 1'b0;
      rec_sh    <= '0;
      silent    <= 1'b0;
      ovf_frame <= 1'b0;
    end else begin
      if (state == IDLE) begin
        silent    <= 1'b0;
        ovf_frame <= 1'b0;
      end else begin
        if (mark_silent) silent <= 1'b1;
        if (mark_ovf) ovf_frame <= 1'b1;
      end
      if (start_hdr) begin
        hdr_idx <= '0;
        uc_ok   <= 1'b1;
        bc_ok   <= 1'b1;
        et_ok   <= 1'b1;
      end else if (state == HDR && rx_dv) begin
        hdr_idx <= hdr_idx + 4'd1;
        if (hdr_idx <= 4'd5) begin
          uc_ok <= uc_now;
          bc_ok <= bc_now;
        end
        if (hdr_idx >= 4'd12) et_ok <= et_now;
      end
      if (load_cnt) begin
        rec_total <= rx_data;
        rec_cnt   <= '0;
        byte_idx  <= '0;
      end else if (state == PAY && rx_dv) begin
        if (byte_idx == 3'd4) begin
          byte_idx <= '0;
          rec_cnt  <= rec_cnt + 8'd1;
        end else begin
          byte_idx <= byte_idx + 3'd1;
        end
        if (byte_idx == 3'd0) rec_b32 <= rx_data[0];
        else if (byte_idx != 3'd4) rec_sh <= {rec_sh[15:0], rx_data};
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= wr_data;
  end

  // Write/commit/read pointers, frame counters and the sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      cmt_ptr        <= '0;
      rd_ptr         <= '0;
      frame_ok_cnt   <= '0;
      frame_drop_cnt <= '0;
      overflow       <= 1'b0;
    end else begin
      if (rollback)   wr_ptr <= cmt_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (commit) cmt_ptr <= wr_ptr;
      if (cmd_vld && cmd_rdy) rd_ptr <= rd_ptr + 1'b1;
      if (commit) frame_ok_cnt <= frame_ok_cnt + 16'd1;
      if (count_drop) frame_drop_cnt <= frame_drop_cnt + 16'd1;
      if (rollback && ovf_frame) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eth_cmd_rx.sv
// tb_eth_cmd_rx: scoreboard bench for eth_cmd_rx; expected commands are queued
// as frames are sent and popped when the DUT hands them over.
module tb_eth_cmd_rx;

  localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
  localparam logic [15:0] ETYPE = 16'h88B5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_dv = 1'b0;
  logic        cmd_rdy = 1'b0;
  logic [32:0] cmd_data;
  logic        cmd_vld;
  logic [15:0] frame_ok_cnt, frame_drop_cnt;
  logic        overflow;

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_ok = 0;
  int          exp_drop = 0;
  logic [32:0] exp_q[$];
  logic [32:0] recs[16];
  logic [32:0] mon_exp;
  logic        junk_hi = 1'b0;

  always #4 clk = ~clk;

  eth_cmd_rx dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_dv(rx_dv),
    .cmd_data(cmd_data), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .frame_ok_cnt(frame_ok_cnt), .frame_drop_cnt(frame_drop_cnt), .overflow(overflow)
  );

  // Scoreboard: every handshake must match the oldest expected command
  always @(negedge clk) begin
    if (rst_n && cmd_vld && cmd_rdy) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("[TB] FAIL unexpected_cmd: got %h, required no command", cmd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (cmd_data !== mon_exp) begin
          n_err++;
          $display("[TB] FAIL cmd_data: got %h, required %h", cmd_data, mon_exp);
        end
      end
    end
  end

  // Global time limit so the bench always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(output bit timed_out);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || cmd_vld) && k < 600) begin
      @(negedge clk);
      k++;
    end
    timed_out = (k >= 600);
  endtask

  task automatic fill_recs(input int n);
    for (int i = 0; i < n; i++) recs[i] = {1'($urandom), 32'($urandom)};
  endtask

  // Builds and drives one frame; cut<0 sends it whole, hold keeps rx_dv high at the end
  task automatic send_frame(input logic [47:0] dst, input logic [15:0] etype, input int ncnt,
                            input int nrec, input int cut, input bit push, input bit hold,
                            input logic [31:0] fcs_xor);
    logic [7:0]  fr[$];
    logic [7:0]  body[$];
    logic [31:0] crc;
    logic [31:0] fcs;
    for (int i = 0; i < 6; i++) body.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) body.push_back(8'(8'h10 + i));
    body.push_back(etype[15:8]);
    body.push_back(etype[7:0]);
    body.push_back(8'(ncnt));
    for (int i = 0; i < nrec; i++) begin
      body.push_back({junk_hi ? 7'($urandom) : 7'h00, recs[i][32]});
      body.push_back(recs[i][31:24]);
      body.push_back(recs[i][23:16]);
      body.push_back(recs[i][15:8]);
      body.push_back(recs[i][7:0]);
    end
    for (int i = 0; i < 3; i++) body.push_back(8'h00);
    crc = 32'hFFFF_FFFF;
    foreach (body[j]) begin
      crc = crc ^ {24'h0, body[j]};
      for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
    end
    fcs = ~crc ^ fcs_xor;
    body.push_back(fcs[7:0]);
    body.push_back(fcs[15:8]);
    body.push_back(fcs[23:16]);
    body.push_back(fcs[31:24]);
    for (int i = 0; i < 7; i++) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    foreach (body[j]) fr.push_back(body[j]);
    if (cut >= 0) while (fr.size() > 8 + cut) void'(fr.pop_back());
    if (push) for (int i = 0; i < nrec; i++) exp_q.push_back(recs[i]);
    foreach (fr[j]) begin
      @(posedge clk);
      #1;
      rx_dv   = 1'b1;
      rx_data = fr[j];
    end
    if (!hold) begin
      @(posedge clk);
      #1;
      rx_dv   = 1'b0;
      rx_data = 8'h00;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_vec++; if (cmd_vld !== 1'b0) begin n_err++; $display("[TB] FAIL reset_vld: got %b, required 0", cmd_vld); end
    n_vec++; if (cmd_data !== 33'h0) begin n_err++; $display("[TB] FAIL reset_data: got %h, required 0", cmd_data); end
    n_vec++; if (frame_ok_cnt !== 16'd0 || frame_drop_cnt !== 16'd0) begin n_err++; $display("[TB] FAIL reset_cnt: got %0d/%0d, required 0/0", frame_ok_cnt, frame_drop_cnt); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ovf: got %b, required 0", overflow); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_valid_frame;
    cmd_rdy = 1'b1;
    recs[0] = 33'h1_0000_0102;
    recs[1] = 33'h0_0001_ABCD;
    send_frame(MAC, ETYPE, 2, 2, -1, 1'b1, 1'b0, 32'h0);
    exp_ok++;
    @(negedge clk);
    n_vec++; if (cmd_vld !== 1'b0) begin n_err++; $display("[TB] FAIL vld_early: got %b, required 0", cmd_vld); end
    @(negedge clk);
    n_vec++; if (cmd_vld !== 1'b1) begin n_err++; $display("[TB] FAIL vld_latency: got %b, required 1", cmd_vld); end
    @(negedge clk);
    n_vec++; if (cmd_vld !== 1'b1) begin n_err++; $display("[TB] FAIL vld_second: got %b, required 1", cmd_vld); end
    @(negedge clk);
    n_vec++; if (cmd_vld !== 1'b0) begin n_err++; $display("[TB] FAIL vld_empty: got %b, required 0", cmd_vld); end
    n_vec++; if (frame_ok_cnt !== 16'(exp_ok)) begin n_err++; $display("[TB] FAIL valid_ok_cnt: got %0d, required %0d", frame_ok_cnt, exp_ok); end
    idle(2);
  endtask

  task automatic test_truncated;
    fill_recs(2);
    send_frame(MAC, ETYPE, 2, 2, 22, 1'b0, 1'b0, 32'h0);
    exp_drop++;
    idle(4);
    n_vec++; if (cmd_vld !== 1'b0) begin n_err++; $display("[TB] FAIL trunc_vld: got %b, required 0", cmd_vld); end
    n_vec++; if (frame_drop_cnt !== 16'(exp_drop)) begin n_err++; $display("[TB] FAIL trunc_drop_cnt: got %0d, required %0d", frame_drop_cnt, exp_drop); end
    n_vec++; if (frame_ok_cnt !== 16'(exp_ok)) begin n_err++; $display("[TB] FAIL trunc_ok_cnt: got %0d, required %0d", frame_ok_cnt, exp_ok); end
  endtask

  task automatic test_filter;
    bit to;
    junk_hi = 1'b1;
    fill_recs(1);
    send_frame(MAC, 16'h0800, 1, 1, -1, 1'b0, 1'b0, 32'h0);
    idle(2);
    send_frame(OTHER, ETYPE, 1, 1, -1, 1'b0, 1'b0, 32'h0);
    idle(2);
    fill_recs(1);
    send_frame(BCAST, ETYPE, 1, 1, -1, 1'b1, 1'b0, 32'h0);
    exp_ok++;
    wait_drain(to);
    n_vec++; if (to) begin n_err++; $display("[TB] FAIL filter_drain: got timeout, required empty"); end
    n_vec++; if (frame_drop_cnt !== 16'(exp_drop)) begin n_err++; $display("[TB] FAIL filter_drop_cnt: got %0d, required %0d", frame_drop_cnt, exp_drop); end
    n_vec++; if (frame_ok_cnt !== 16'(exp_ok)) begin n_err++; $display("[TB] FAIL filter_ok_cnt: got %0d, required %0d", frame_ok_cnt, exp_ok); end
  endtask

  task automatic test_count_bounds;
    bit to;
    fill_recs(16);
    send_frame(MAC, ETYPE, 0, 0, -1, 1'b0, 1'b0, 32'h0);
    exp_drop++;
    idle(2);
    send_frame(MAC, ETYPE, 17, 2, -1, 1'b0, 1'b0, 32'h0);
    exp_drop++;
    idle(2);
    send_frame(MAC, ETYPE, 16, 16, -1, 1'b1, 1'b0, 32'h0);
    exp_ok++;
    wait_drain(to);
    n_vec++; if (to) begin n_err++; $display("[TB] FAIL bounds_drain: got timeout, required empty"); end
    n_vec++; if (frame_drop_cnt !== 16'(exp_drop)) begin n_err++; $display("[TB] FAIL bounds_drop_cnt: got %0d, required %0d", frame_drop_cnt, exp_drop); end
    n_vec++; if (frame_ok_cnt !== 16'(exp_ok)) begin n_err++; $display("[TB] FAIL bounds_ok_cnt: got %0d, required %0d", frame_ok_cnt, exp_ok); end
    junk_hi = 1'b0;
  endtask

  task automatic test_overflow;
    bit to;
    cmd_rdy = 1'b0;
    fill_recs(10);
    send_frame(MAC, ETYPE, 10, 10, -1, 1'b1, 1'b0, 32'h0);
    exp_ok++;
    idle(2);
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("[TB] FAIL ovf_early: got %b, required 0", overflow); end
    fill_recs(10);
    send_frame(MAC, ETYPE, 10, 10, -1, 1'b0, 1'b0, 32'h0);
    exp_drop++;
    idle(2);
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("[TB] FAIL ovf_set: got %b, required 1", overflow); end
    n_vec++; if (frame_drop_cnt !== 16'(exp_drop)) begin n_err++; $display("[TB] FAIL ovf_drop_cnt: got %0d, required %0d", frame_drop_cnt, exp_drop); end
    n_vec++; if (frame_ok_cnt !== 16'(exp_ok)) begin n_err++; $display("[TB] FAIL ovf_ok_cnt: got %0d, required %0d", frame_ok_cnt, exp_ok); end
    cmd_rdy = 1'b1;
    wait_drain(to);
    n_vec++; if (to) begin n_err++; $display("[TB] FAIL ovf_drain: got timeout, required empty"); end
  endtask

  task automatic test_back_to_back;
    bit to;
    fork
      begin
        fill_recs(5);
        send_frame(MAC, ETYPE, 5, 5, -1, 1'b1, 1'b0, 32'h0);
        idle(1);
        fill_recs(7);
        send_frame(BCAST, ETYPE, 7, 7, -1, 1'b1, 1'b0, 32'h0);
      end
      begin
        repeat (150) begin
          @(posedge clk);
          #1 cmd_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    exp_ok += 2;
    cmd_rdy = 1'b1;
    wait_drain(to);
    n_vec++; if (to) begin n_err++; $display("[TB] FAIL b2b_drain: got timeout, required empty"); end
    n_vec++; if (frame_ok_cnt !== 16'(exp_ok)) begin n_err++; $display("[TB] FAIL b2b_ok_cnt: got %0d, required %0d", frame_ok_cnt, exp_ok); end
  endtask

`ifdef ETH_CMD_RX_FCS_CHECK_EN
  task automatic test_fcs;
    bit to;
    cmd_rdy = 1'b1;
    fill_recs(3);
    send_frame(MAC, ETYPE, 3, 3, -1, 1'b1, 1'b0, 32'h0);
    exp_ok++;
    idle(2);
    send_frame(MAC, ETYPE, 3, 3, -1, 1'b0, 1'b0, 32'h0000_0100);
    exp_drop++;
    wait_drain(to);
    idle(2);
    n_vec++; if (to) begin n_err++; $display("[TB] FAIL fcs_drain: got timeout, required empty"); end
    n_vec++; if (frame_ok_cnt !== 16'(exp_ok)) begin n_err++; $display("[TB] FAIL fcs_ok_cnt: got %0d, required %0d", frame_ok_cnt, exp_ok); end
    n_vec++; if (frame_drop_cnt !== 16'(exp_drop)) begin n_err++; $display("[TB] FAIL fcs_drop_cnt: got %0d, required %0d", frame_drop_cnt, exp_drop); end
  endtask
`endif

  task automatic test_reset_mid_frame;
    bit to;
    cmd_rdy = 1'b0;
    fill_recs(2);
    send_frame(MAC, ETYPE, 2, 2, -1, 1'b1, 1'b0, 32'h0);
    idle(2);
    n_vec++; if (cmd_vld !== 1'b1) begin n_err++; $display("[TB] FAIL pending_vld: got %b, required 1", cmd_vld); end
    fill_recs(3);
    send_frame(MAC, ETYPE, 3, 3, 23, 1'b0, 1'b1, 32'h0);
    rst_n = 1'b0;
    exp_q.delete();
    exp_ok = 0;
    exp_drop = 0;
    #1;
    n_vec++; if (cmd_vld !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_vld: got %b, required 0", cmd_vld); end
    n_vec++; if (frame_ok_cnt !== 16'd0 || frame_drop_cnt !== 16'd0) begin n_err++; $display("[TB] FAIL midrst_cnt: got %0d/%0d, required 0/0", frame_ok_cnt, frame_drop_cnt); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_ovf: got %b, required 0", overflow); end
    @(posedge clk);
    #1 rx_dv = 1'b0;
    idle(2);
    rst_n = 1'b1;
    cmd_rdy = 1'b1;
    idle(2);
    fill_recs(1);
    send_frame(MAC, ETYPE, 1, 1, -1, 1'b1, 1'b0, 32'h0);
    exp_ok++;
    wait_drain(to);
    n_vec++; if (to) begin n_err++; $display("[TB] FAIL postrst_drain: got timeout, required empty"); end
    n_vec++; if (frame_ok_cnt !== 16'(exp_ok) || frame_drop_cnt !== 16'(exp_drop)) begin n_err++; $display("[TB] FAIL postrst_cnt: got %0d/%0d, required %0d/%0d", frame_ok_cnt, frame_drop_cnt, exp_ok, exp_drop); end
  endtask

  initial begin
    test_reset;
    test_valid_frame;
    test_truncated;
    test_filter;
    test_count_bounds;
    test_overflow;
    test_back_to_back;
`ifdef ETH_CMD_RX_FCS_CHECK_EN
    test_fcs;
`endif
    test_reset_mid_frame;
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
